// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared front-end fetch types
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction queue with same-cycle flush
module fetch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output fetch_entry_t               head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue only lands when the head leaves in the same cycle.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push && !flush_i) mem_q[tail_q] <= push_entry_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC sequencing, single-outstanding icache reads
module fetch_controller
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic          push;
    logic          pop;
    logic [PW:0]   count;
    logic [PW+1:0] post_cnt;
    logic          has_room;
    logic [31:0]   target_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign pop        = out_valid & out_ready;
    assign has_room   = ({1'b0, count} < (PW + 2)'(DEPTH));
    assign post_cnt   = {1'b0, count} + (PW + 2)'(1) - (PW + 2)'(pop);
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect)      pc_d    = target_pc;
                else if (has_room) state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d = target_pc;
                    // The outstanding read cannot be cancelled; wait it out in DROP.
                    if (!imem_resp) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_resp) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = (post_cnt < (PW + 2)'(DEPTH)) ? FETCH : IDLE;
                end
            end
            DROP: begin
                if (redirect)  pc_d    = target_pc;
                if (imem_resp) state_d = has_room ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        imem_read    = 1'b0;
        imem_address = '0;
        case (state_q)
            FETCH: begin
                imem_read    = 1'b1;
                imem_address = pc_q;
            end
            DROP: begin
                imem_read    = 1'b1;
                imem_address = drop_addr_q;
            end
            default: ;
        endcase
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect),
        .count_o      (count),
        .head_o       (head)
    );

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule
